ex_muldiv: RTL

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide over WIDTH cycles.
// Latency: ow_done first high WIDTH+2 cycles after the accept cycle (2 for divides without MULDIV_DIV_EN).
// Backpressure: iw_stall holds the completed result in DONE; ow_ready is high only in IDLE.
// Configuration: define MULDIV_DIV_EN to build the divider datapath (DIVU/DIVS); otherwise divides return 0 with V set.
module ex_muldiv #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input  logic             iw_clk,
    input  logic             iw_rst,
    input  logic             iw_valid,
    output logic             ow_ready,
    input  logic [1:0]       iw_op,
    input  logic [WIDTH-1:0] iw_a,
    input  logic [WIDTH-1:0] iw_b,
    input  logic             iw_flush,
    input  logic             iw_stall,
    output logic             ow_busy,
    output logic             ow_done,
    output logic [WIDTH-1:0] ow_lo,
    output logic [WIDTH-1:0] ow_hi,
    output logic [3:0]       ow_flags
);

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
`ifdef MULDIV_DIV_EN
    localparam logic [1:0] OP_DIVS = 2'b11;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     hi_q;        // partial product high half / partial remainder
    logic [WIDTH-1:0]     lo_q;        // multiplier shifting out / dividend-then-quotient
    logic [WIDTH-1:0]     opnd_q;      // multiplicand or divisor magnitude
    logic                 neg_res_q;   // product or quotient must be negated in FIX
    logic [WIDTH-1:0]     res_lo_q;
    logic [WIDTH-1:0]     res_hi_q;
    logic [3:0]           flags_q;
`ifdef MULDIV_DIV_EN
    logic                 neg_rem_q;   // remainder takes the dividend's sign
    logic [WIDTH-1:0]     a_q;         // raw dividend, returned as remainder on divide-by-zero
    logic                 div0_q;
    logic                 ovf_q;       // most-negative / -1
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
`endif

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH-1:0]     step_hi_d;
    logic [WIDTH-1:0]     step_lo_d;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     fix_lo_d;
    logic [WIDTH-1:0]     fix_hi_d;
    logic [3:0]           fix_flags_d;

    // Operand magnitudes at accept; only the signed ops (op[0]=1) look at the sign bits
    always_comb begin
        a_neg = iw_op[0] & iw_a[WIDTH-1];
        b_neg = iw_op[0] & iw_b[WIDTH-1];
        a_mag = a_neg ? -iw_a : iw_a;
        b_mag = b_neg ? -iw_b : iw_b;
    end

    // One radix-2 iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        step_hi_d = mul_sum[WIDTH:1];
        step_lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        // When the subtract succeeds the difference is below the divisor, so WIDTH bits suffice
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (op_q[1]) begin
            step_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo_d = {lo_q[WIDTH-2:0], div_ge};
        end
`endif
    end

    // Sign correction and flag generation for the FIX cycle
    always_comb begin
        prod_fix    = neg_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        fix_lo_d    = prod_fix[WIDTH-1:0];
        fix_hi_d    = prod_fix[2*WIDTH-1:WIDTH];
        fix_flags_d = {prod_fix == '0,
                       (op_q == OP_MULS) & prod_fix[2*WIDTH-1],
                       (op_q == OP_MULU) & (|prod_fix[2*WIDTH-1:WIDTH]),
                       (op_q == OP_MULS) & (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}})};
        if (op_q[1]) begin
`ifdef MULDIV_DIV_EN
            if (div0_q) begin
                fix_lo_d = '1;
                fix_hi_d = a_q;
            end else begin
                // Most-negative / -1 falls out naturally: magnitude 2^(W-1), positive sign, remainder 0
                fix_lo_d = neg_res_q ? -lo_q : lo_q;
                fix_hi_d = neg_rem_q ? -hi_q : hi_q;
            end
            fix_flags_d = {fix_lo_d == '0, (op_q == OP_DIVS) & fix_lo_d[WIDTH-1], 1'b0, div0_q | ovf_q};
`else
            fix_lo_d    = '0;
            fix_hi_d    = '0;
            fix_flags_d = 4'b0001;
`endif
        end
    end

    // Control FSM and datapath registers; reset beats flush, flush beats accept/stall
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MULU;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            flags_q   <= '0;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iw_valid && !iw_flush) begin
                        op_q      <= iw_op;
                        cnt_q     <= CNT_W'(WIDTH - 1);
                        hi_q      <= '0;
                        neg_res_q <= a_neg ^ b_neg;
                        if (iw_op[1]) begin
                            lo_q   <= a_mag;
                            opnd_q <= b_mag;
                        end else begin
                            lo_q   <= b_mag;
                            opnd_q <= a_mag;
                        end
`ifdef MULDIV_DIV_EN
                        neg_rem_q <= a_neg;
                        a_q       <= iw_a;
                        div0_q    <= (iw_b == '0);
                        ovf_q     <= (iw_op == OP_DIVS) && (iw_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&iw_b);
                        state_q   <= ST_RUN;
`else
                        state_q   <= iw_op[1] ? ST_FIX : ST_RUN;
`endif
                    end
                end
                ST_RUN: begin
                    if (iw_flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hi_q  <= step_hi_d;
                        lo_q  <= step_lo_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (iw_flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        res_lo_q <= fix_lo_d;
                        res_hi_q <= fix_hi_d;
                        flags_q  <= fix_flags_d;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (iw_flush || !iw_stall) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ow_ready = (state_q == ST_IDLE);
    assign ow_busy  = (state_q != ST_IDLE);
    assign ow_done  = (state_q == ST_DONE) && !iw_stall && !iw_flush;
    assign ow_lo    = res_lo_q;
    assign ow_hi    = res_hi_q;
    assign ow_flags = flags_q;

endmodule
